// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a five-stage in-order pipeline.
// Owns the stage valid bits, the stage register load enables, the operand
// forwarding selects and a load-use stall performance counter.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_wreg,
    input  logic [4:0]       mem_wreg,
    input  logic [4:0]       wb_wreg,
    input  logic             ex_wen,
    input  logic             mem_wen,
    input  logic             wb_wen,
    input  logic             ex_is_load,
    input  logic             mem_is_load,
    input  logic             dmem_stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_INIT   = 2'b00,
        S_RUN    = 2'b01,
        S_LSTALL = 2'b10,
        S_MSTALL = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_id_valid, r_ex_valid, r_mem_valid, r_wb_valid;
    logic             w_id_valid_nx, w_ex_valid_nx, w_mem_valid_nx, w_wb_valid_nx;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_cnt_inc;
    logic             w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic             w_ex_load, w_mem_load;
    logic             w_rs_haz, w_rt_haz, w_hazard;
    logic             w_ex_fwd_ok, w_mem_fwd_ok, w_wb_fwd_ok;
    logic [1:0]       w_fwd_a, w_fwd_b;

    // Youngest eligible writer wins; register 0 never forwards.
    function automatic logic [1:0] pick_src(
        input logic [4:0] src,
        input logic [4:0] ex_r,
        input logic [4:0] mem_r,
        input logic [4:0] wb_r,
        input logic       ex_ok,
        input logic       mem_ok,
        input logic       wb_ok
    );
        if (src == 5'd0)             return 2'b00;
        if (ex_ok  && (ex_r  == src)) return 2'b01;
        if (mem_ok && (mem_r == src)) return 2'b10;
        if (wb_ok  && (wb_r  == src)) return 2'b11;
        return 2'b00;
    endfunction

    // Load-use hazard: a used, non-zero source matches a valid load in EX or MEM.
    assign w_ex_load  = r_ex_valid  & ex_wen  & ex_is_load;
    assign w_mem_load = r_mem_valid & mem_wen & mem_is_load;
    assign w_rs_haz   = id_use_rs && (id_rs != 5'd0) &&
                        ((w_ex_load && (ex_wreg == id_rs)) || (w_mem_load && (mem_wreg == id_rs)));
    assign w_rt_haz   = id_use_rt && (id_rt != 5'd0) &&
                        ((w_ex_load && (ex_wreg == id_rt)) || (w_mem_load && (mem_wreg == id_rt)));
    assign w_hazard   = r_id_valid & (w_rs_haz | w_rt_haz);

    // Loads in EX/MEM have no data yet, so they are excluded as forwarding sources.
    assign w_ex_fwd_ok  = r_ex_valid  & ex_wen  & ~ex_is_load;
    assign w_mem_fwd_ok = r_mem_valid & mem_wen & ~mem_is_load;
    assign w_wb_fwd_ok  = r_wb_valid  & wb_wen;
    assign w_fwd_a = pick_src(id_rs, ex_wreg, mem_wreg, wb_wreg, w_ex_fwd_ok, w_mem_fwd_ok, w_wb_fwd_ok);
    assign w_fwd_b = pick_src(id_rt, ex_wreg, mem_wreg, wb_wreg, w_ex_fwd_ok, w_mem_fwd_ok, w_wb_fwd_ok);

    // Next-state, enable and valid-bit decode. Every state except INIT behaves
    // identically: memory freeze first, then load-use stall, then advance.
    always_comb begin
        w_next_state   = r_state;
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        w_id_valid_nx  = r_id_valid;
        w_ex_valid_nx  = r_ex_valid;
        w_mem_valid_nx = r_mem_valid;
        w_wb_valid_nx  = r_wb_valid;
        w_cnt_inc      = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_pc_en       = 1'b1;
                w_id_valid_nx = 1'b1;
                w_next_state  = S_RUN;
            end
            default: begin
                if (dmem_stall) begin
                    w_next_state = S_MSTALL;
                end else if (w_hazard) begin
                    w_id_ex_en     = 1'b1;
                    w_ex_mem_en    = 1'b1;
                    w_mem_wb_en    = 1'b1;
                    w_ex_valid_nx  = 1'b0;
                    w_mem_valid_nx = r_ex_valid;
                    w_wb_valid_nx  = r_mem_valid;
                    w_cnt_inc      = 1'b1;
                    w_next_state   = S_LSTALL;
                end else begin
                    w_pc_en        = 1'b1;
                    w_if_id_en     = 1'b1;
                    w_id_ex_en     = 1'b1;
                    w_ex_mem_en    = 1'b1;
                    w_mem_wb_en    = 1'b1;
                    w_id_valid_nx  = 1'b1;
                    w_ex_valid_nx  = r_id_valid;
                    w_mem_valid_nx = r_ex_valid;
                    w_wb_valid_nx  = r_mem_valid;
                    w_next_state   = S_RUN;
                end
            end
        endcase
    end

    // State, valid bits and stall counter; reset drops all in-flight work.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_INIT;
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_state     <= w_next_state;
            r_id_valid  <= w_id_valid_nx;
            r_ex_valid  <= w_ex_valid_nx;
            r_mem_valid <= w_mem_valid_nx;
            r_wb_valid  <= w_wb_valid_nx;
            if (w_cnt_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // NOTE: enables and selects decode combinationally (INIT alone would raise
    // pc_en), so they are gated by resetn to read zero for as long as reset is held.
    assign pc_en     = resetn & w_pc_en;
    assign if_id_en  = resetn & w_if_id_en;
    assign id_ex_en  = resetn & w_id_ex_en;
    assign ex_mem_en = resetn & w_ex_mem_en;
    assign mem_wb_en = resetn & w_mem_wb_en;
    assign fwd_a_sel = resetn ? w_fwd_a : 2'b00;
    assign fwd_b_sel = resetn ? w_fwd_b : 2'b00;
    assign id_valid  = r_id_valid;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;
    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus for pipe_ctrl, checked every cycle against a
// stage-occupancy model, plus hand-computed literal expectations.
module tb_pipe_ctrl;

    logic        clk;
    logic        resetn;
    logic [4:0]  id_rs, id_rt, ex_wreg, mem_wreg, wb_wreg;
    logic        id_use_rs, id_use_rt, ex_wen, mem_wen, wb_wen;
    logic        ex_is_load, mem_is_load, dmem_stall;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        id_valid, ex_valid, mem_valid, wb_valid;
    logic [1:0]  fwd_a_sel, fwd_b_sel, state;
    logic [31:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load), .dmem_stall(dmem_stall),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_v holds stage occupancy {wb, mem, ex, id}; m_state records what the
    // previous cycle did (INIT, advanced, bubbled, frozen).
    localparam logic [1:0] E_INIT = 2'd0, E_RUN = 2'd1, E_LSTALL = 2'd2, E_MSTALL = 2'd3;
    logic [1:0]  m_state = E_INIT;
    logic [3:0]  m_v     = 4'b0000;
    logic [31:0] m_cnt   = 32'd0;
    logic [31:0] m_adj   = 32'd0;   // offset applied when the DUT counter is forced

    function automatic logic m_load_hit(input logic [4:0] r);
        return (r != 5'd0) &&
               ((m_v[1] && ex_wen  && ex_is_load  && (ex_wreg  == r)) ||
                (m_v[2] && mem_wen && mem_is_load && (mem_wreg == r)));
    endfunction

    function automatic logic m_hazard();
        return m_v[0] && ((id_use_rs && m_load_hit(id_rs)) || (id_use_rt && m_load_hit(id_rt)));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        logic [4:0] wr[3];
        logic       ok[3];
        wr[0] = ex_wreg;  ok[0] = m_v[1] && ex_wen  && !ex_is_load;
        wr[1] = mem_wreg; ok[1] = m_v[2] && mem_wen && !mem_is_load;
        wr[2] = wb_wreg;  ok[2] = m_v[3] && wb_wen;
        if (r == 5'd0) return 2'b00;
        for (int i = 0; i < 3; i++)
            if (ok[i] && wr[i] == r) return 2'(i + 1);
        return 2'b00;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_state <= E_INIT;
            m_v     <= 4'b0000;
            m_cnt   <= 32'd0;
        end else if (m_state == E_INIT) begin
            m_state <= E_RUN;
            m_v     <= 4'b0001;
        end else if (dmem_stall) begin
            m_state <= E_MSTALL;
        end else if (m_hazard()) begin
            m_state <= E_LSTALL;
            m_v     <= {m_v[2], m_v[1], 1'b0, m_v[0]};
            m_cnt   <= m_cnt + 32'd1;
        end else begin
            m_state <= E_RUN;
            m_v     <= {m_v[2], m_v[1], m_v[0], 1'b1};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic compare_model();
        logic [4:0] exp_en;
        if (!resetn)                exp_en = 5'b00000;
        else if (m_state == E_INIT) exp_en = 5'b10000;
        else if (dmem_stall)        exp_en = 5'b00000;
        else if (m_hazard())        exp_en = 5'b00111;
        else                        exp_en = 5'b11111;
        check("model_enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(exp_en));
        check("model_valids",  32'({wb_valid, mem_valid, ex_valid, id_valid}), 32'(m_v));
        check("model_fwd_a",   32'(fwd_a_sel), resetn ? 32'(m_fwd(id_rs)) : 32'd0);
        check("model_fwd_b",   32'(fwd_b_sel), resetn ? 32'(m_fwd(id_rt)) : 32'd0);
        check("model_state",   32'(state), 32'(m_state));
        check("model_cnt",     stall_cnt, m_cnt + m_adj);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_wreg = 0; mem_wreg = 0; wb_wreg = 0;
        ex_wen = 0; mem_wen = 0; wb_wen = 0;
        ex_is_load = 0; mem_is_load = 0; dmem_stall = 0;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
        compare_model();
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_in();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        ex_wen = 1; ex_wreg = 5'd3; id_rs = 5'd3; id_use_rs = 1;
        edge_step();
        half();
        chk1("rst_pc_en", pc_en, 1'b0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        edge_step();

        // Reset release: INIT then RUN, pipeline fills by cycle 4.
        resetn = 1'b1;
        clear_in();
        half();
        chk1("c0_pc_en", pc_en, 1'b1);
        chk1("c0_if_id_en", if_id_en, 1'b0);
        check("c0_state", 32'(state), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            edge_step();
            half();
            if (c == 1) begin
                check("c1_state", 32'(state), 32'd1);
                chk1("c1_id_valid", id_valid, 1'b1);
            end
        end
        chk1("c4_wb_valid", wb_valid, 1'b1);
        check("c4_stall_cnt", stall_cnt, 32'd0);
        edge_step();

        // Forwarding priority and r0 exclusion.
        ex_wen = 1; ex_wreg = 5'd7; mem_wen = 1; mem_wreg = 5'd7; id_rt = 5'd7; id_use_rt = 1;
        half();
        check("fwd_ex_wins", 32'(fwd_b_sel), 32'd1);
        edge_step();
        ex_wen = 0;
        half();
        check("fwd_mem", 32'(fwd_b_sel), 32'd2);
        edge_step();
        mem_wen = 0; wb_wen = 1; wb_wreg = 5'd7;
        half();
        check("fwd_wb", 32'(fwd_b_sel), 32'd3);
        edge_step();
        ex_wen = 1; mem_wen = 1; id_rt = 5'd0; id_rs = 5'd7;
        half();
        check("fwd_r0", 32'(fwd_b_sel), 32'd0);
        check("fwd_a_ex", 32'(fwd_a_sel), 32'd1);
        edge_step();
        clear_in();
        ex_wen = 1; ex_is_load = 1; ex_wreg = 5'd7; mem_wen = 1; mem_wreg = 5'd7; id_rt = 5'd7;
        half();
        check("fwd_skip_load", 32'(fwd_b_sel), 32'd2);
        chk1("no_use_no_stall", pc_en, 1'b1);
        edge_step();

        // Load in EX feeding rs: two stall cycles then RUN.
        clear_in();
        ex_wen = 1; ex_is_load = 1; ex_wreg = 5'd5; id_rs = 5'd5; id_use_rs = 1;
        half();
        chk1("lu_a_pc_en", pc_en, 1'b0);
        chk1("lu_a_if_id_en", if_id_en, 1'b0);
        chk1("lu_a_id_ex_en", id_ex_en, 1'b1);
        edge_step();
        ex_wen = 0; ex_is_load = 0; ex_wreg = 0;
        mem_wen = 1; mem_is_load = 1; mem_wreg = 5'd5;
        half();
        check("lu_b_state", 32'(state), 32'd2);
        chk1("lu_b_bubble", ex_valid, 1'b0);
        chk1("lu_b_pc_en", pc_en, 1'b0);
        edge_step();
        mem_wen = 0; mem_is_load = 0; mem_wreg = 0; wb_wen = 1; wb_wreg = 5'd5;
        half();
        chk1("lu_c_pc_en", pc_en, 1'b1);
        check("lu_c_fwd_wb", 32'(fwd_a_sel), 32'd3);
        check("lu_c_cnt", stall_cnt, 32'd2);
        edge_step();
        clear_in();
        half();
        check("lu_run", 32'(state), 32'd1);
        edge_step();

        // Memory freeze during a load-use stall.
        ex_wen = 1; ex_is_load = 1; ex_wreg = 5'd9; id_rt = 5'd9; id_use_rt = 1;
        half();
        edge_step();
        ex_wen = 0; ex_is_load = 0; ex_wreg = 0;
        mem_wen = 1; mem_is_load = 1; mem_wreg = 5'd9; dmem_stall = 1;
        for (int k = 0; k < 3; k++) begin
            half();
            check("ms_enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'd0);
            check("ms_cnt_frozen", stall_cnt, 32'd3);
            if (k > 0) check("ms_state", 32'(state), 32'd3);
            edge_step();
        end
        dmem_stall = 0;
        half();
        check("ms_exit_state", 32'(state), 32'd3);
        chk1("ms_resume_pc_en", pc_en, 1'b0);
        chk1("ms_resume_id_ex", id_ex_en, 1'b1);
        edge_step();
        mem_wen = 0; mem_is_load = 0; mem_wreg = 0; wb_wen = 1; wb_wreg = 5'd9;
        half();
        check("ms_after_state", 32'(state), 32'd2);
        check("ms_after_cnt", stall_cnt, 32'd4);
        edge_step();

        // Counter wrap from all-ones.
        clear_in();
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        m_adj = 32'hFFFF_FFFF - m_cnt;
        #1 release dut.r_stall_cnt;
        ex_wen = 1; ex_is_load = 1; ex_wreg = 5'd4; id_rs = 5'd4; id_use_rs = 1;
        half();
        check("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
        edge_step();
        clear_in();
        half();
        check("wrap_post", stall_cnt, 32'd0);
        edge_step();

        // Asynchronous reset while in LSTALL.
        ex_wen = 1; ex_is_load = 1; ex_wreg = 5'd6; id_rs = 5'd6; id_use_rs = 1;
        half();
        edge_step();
        ex_wen = 0; ex_is_load = 0; ex_wreg = 0;
        mem_wen = 1; mem_is_load = 1; mem_wreg = 5'd6; wb_wen = 1; wb_wreg = 5'd6;
        #1;
        check("ar_pre_state", 32'(state), 32'd2);
        chk1("ar_pre_id_valid", id_valid, 1'b1);
        resetn = 1'b0;
        m_adj  = 32'd0;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_valids", 32'({wb_valid, mem_valid, ex_valid, id_valid}), 32'd0);
        chk1("ar_pc_en", pc_en, 1'b0);
        check("ar_cnt", stall_cnt, 32'd0);
        half();
        edge_step();
        resetn = 1'b1;
        clear_in();
        for (int c = 0; c < 3; c++) begin
            half();
            edge_step();
        end
        half();
        check("final_state", 32'(state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
